// File: rtl/reg_select_pkg.sv
// Shared definitions for the register-select decoder: FSM state encoding and
// a fixed-width one-hot helper for the default 4-to-16 configuration.
package reg_select_pkg;

  localparam int DEF_IN_W  = 4;
  localparam int DEF_OUT_W = 1 << DEF_IN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [DEF_OUT_W-1:0] onehot(input logic [DEF_IN_W-1:0] idx);
    onehot = {{(DEF_OUT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational IN_W-to-2^IN_W one-hot decode, shared by the direct and
// sweep select paths.
module onehot_decoder #(
  parameter  int IN_W  = 4,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic [IN_W-1:0]  idx,
  output logic [OUT_W-1:0] onehot
);

  assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/reg_select_decoder.sv
// Registered one-hot select decoder with a sweep mode that walks the output
// through lo..hi one index per cycle for register-file init and scan readout.
module reg_select_decoder
  import reg_select_pkg::*;
#(
  parameter  int IN_W  = 4,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic [IN_W-1:0]  sel_in,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  sweep_lo,
  input  logic [IN_W-1:0]  sweep_hi,
  output logic [OUT_W-1:0] sel_out,
  output logic [IN_W-1:0]  sweep_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t          state;
  logic [IN_W-1:0] hi;
  logic [IN_W-1:0] cur;
  logic [IN_W-1:0] cur_next;
  logic [IN_W-1:0] dec_idx;
  logic [OUT_W-1:0] dec_out;
  logic            accept;

  assign accept   = start && (sweep_lo <= sweep_hi);
  assign cur_next = cur + {{(IN_W-1){1'b0}}, 1'b1};

  // One decoder serves both paths; in IDLE it sees the requested index,
  // in SWEEP it sees the next step so sel_out stays registered.
  always_comb begin
    dec_idx = cur_next;
    if (state == IDLE)
      dec_idx = accept ? sweep_lo : sel_in;
  end

  onehot_decoder #(.IN_W(IN_W)) u_dec (
    .idx    (dec_idx),
    .onehot (dec_out)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      hi        <= '0;
      cur       <= '0;
      sel_out   <= '0;
      sweep_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            hi        <= sweep_hi;
            cur       <= sweep_lo;
            sel_out   <= dec_out;
            sweep_idx <= sweep_lo;
            busy      <= 1'b1;
            state     <= SWEEP;
          end else begin
            err       <= start;
            sel_out   <= en ? dec_out : '0;
            sweep_idx <= '0;
            busy      <= 1'b0;
          end
        end
        SWEEP: begin
          if (abort) begin
            sel_out   <= '0;
            sweep_idx <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (cur == hi) begin
            sel_out   <= '0;
            sweep_idx <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cur       <= cur_next;
            sweep_idx <= cur_next;
            sel_out   <= dec_out;
          end
        end
        DONE: begin
          sel_out   <= '0;
          sweep_idx <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          sel_out   <= '0;
          sweep_idx <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_select_decoder.sv
// Directed bench for reg_select_decoder: a table of direct-decode vectors
// plus hand-written sweep, abort, reject and clear sequences.
module tb_reg_select_decoder;

  logic        clock = 1'b0;
  logic        clear;
  logic        en;
  logic [3:0]  sel_in;
  logic        start;
  logic        abort;
  logic [3:0]  sweep_lo;
  logic [3:0]  sweep_hi;
  logic [15:0] sel_out;
  logic [3:0]  sweep_idx;
  logic        busy;
  logic        done;
  logic        err;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        en;
    logic [3:0]  sel;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[17];

  reg_select_decoder #(.IN_W(4)) dut (
    .clock     (clock),
    .clear     (clear),
    .en        (en),
    .sel_in    (sel_in),
    .start     (start),
    .abort     (abort),
    .sweep_lo  (sweep_lo),
    .sweep_hi  (sweep_hi),
    .sel_out   (sel_out),
    .sweep_idx (sweep_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] s, input logic st,
                               input logic ab, input logic [3:0] lo, input logic [3:0] hi);
    en = e; sel_in = s; start = st; abort = ab; sweep_lo = lo; sweep_hi = hi;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic checkAll(input string name, input logic [15:0] e_sel, input logic [3:0] e_idx,
                          input logic e_busy, input logic e_done, input logic e_err);
    checkOutput({name, ".sel_out"},   32'(sel_out),   32'(e_sel));
    checkOutput({name, ".sweep_idx"}, 32'(sweep_idx), 32'(e_idx));
    checkOutput({name, ".busy"},      32'(busy),      32'(e_busy));
    checkOutput({name, ".done"},      32'(done),      32'(e_done));
    checkOutput({name, ".err"},       32'(err),       32'(e_err));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd0,  16'h0001};
    vecs[1]  = '{1'b1, 4'd1,  16'h0002};
    vecs[2]  = '{1'b1, 4'd2,  16'h0004};
    vecs[3]  = '{1'b1, 4'd3,  16'h0008};
    vecs[4]  = '{1'b1, 4'd4,  16'h0010};
    vecs[5]  = '{1'b1, 4'd5,  16'h0020};
    vecs[6]  = '{1'b1, 4'd6,  16'h0040};
    vecs[7]  = '{1'b1, 4'd7,  16'h0080};
    vecs[8]  = '{1'b1, 4'd8,  16'h0100};
    vecs[9]  = '{1'b1, 4'd9,  16'h0200};
    vecs[10] = '{1'b1, 4'd10, 16'h0400};
    vecs[11] = '{1'b1, 4'd11, 16'h0800};
    vecs[12] = '{1'b1, 4'd12, 16'h1000};
    vecs[13] = '{1'b1, 4'd13, 16'h2000};
    vecs[14] = '{1'b1, 4'd14, 16'h4000};
    vecs[15] = '{1'b1, 4'd15, 16'h8000};
    vecs[16] = '{1'b0, 4'd9,  16'h0000};

    clear = 1'b1;
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    step();
    checkAll("reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    step();
    checkAll("post_reset", 16'h0020, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].en, vecs[i].sel, 1'b0, 1'b0, 4'd0, 4'd0);
      step();
      checkOutput($sformatf("direct[%0d]", i), 32'(sel_out), 32'(vecs[i].exp));
    end

    // sweep 3..6
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 4'd6);
    step();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkAll("sw36_c0", 16'h0008, 4'd3, 1'b1, 1'b0, 1'b0);
    step(); checkAll("sw36_c1", 16'h0010, 4'd4, 1'b1, 1'b0, 1'b0);
    step(); checkAll("sw36_c2", 16'h0020, 4'd5, 1'b1, 1'b0, 1'b0);
    step(); checkAll("sw36_c3", 16'h0040, 4'd6, 1'b1, 1'b0, 1'b0);
    step(); checkAll("sw36_done", 16'h0000, 4'd0, 1'b1, 1'b1, 1'b0);
    step(); checkAll("sw36_idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    // lo == hi == 15
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 4'd15);
    step();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkAll("sw15_c0", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0);
    step(); checkAll("sw15_done", 16'h0000, 4'd0, 1'b1, 1'b1, 1'b0);
    step(); checkAll("sw15_idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    // rejected range, direct path still decodes
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 4'd9, 4'd2);
    step();
    checkAll("reject", 16'h0080, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    checkAll("reject_after", 16'h0080, 4'd0, 1'b0, 1'b0, 1'b0);

    // abort on the second sweep cycle of 0..15
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd15);
    step();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkAll("ab_c0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    checkAll("ab_c1", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkAll("ab_stop", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkAll("ab_nodone", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    // start beats en
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 4'd10, 4'd11);
    step();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkAll("prec_c0", 16'h0400, 4'd10, 1'b1, 1'b0, 1'b0);
    step(); checkAll("prec_c1", 16'h0800, 4'd11, 1'b1, 1'b0, 1'b0);
    step(); checkAll("prec_done", 16'h0000, 4'd0, 1'b1, 1'b1, 1'b0);
    step();

    // clear mid-sweep
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd15);
    step();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    checkAll("clr_c1", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checkAll("clr_hit", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkAll("clr_after", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    // start pulse during a sweep is ignored, even with a bad range
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 4'd5);
    step();
    checkAll("ign_c0", 16'h0010, 4'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 4'd8, 4'd1);
    step();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkAll("ign_c1", 16'h0020, 4'd5, 1'b1, 1'b0, 1'b0);
    step();
    checkAll("ign_done", 16'h0000, 4'd0, 1'b1, 1'b1, 1'b0);
    step();
    checkAll("ign_idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
